a_restoring_div: RTL and testbench

//  Sequential approximate unsigned restoring divider; the inverse of the approximate Vedic multiplier path in the DCT datapath.

---
 rtl/a_restoring_div_if.sv | 27 ++
 rtl/a_restoring_div.sv | 109 ++++++++++
 tb/tb_a_restoring_div.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/a_restoring_div_if.sv
// Operand/result handshake bundle for the restoring divider.
// master = producer of operands and consumer of results; slave = the divider.
interface a_restoring_div_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Both channels are valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both 1. Data is held stable while valid=1.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/a_restoring_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock MSB first.
// Trial subtract is exact above APPROX_BITS-1 and XOR-only (borrow-free) below.
module a_restoring_div #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    a_restoring_div_if.slave       bus,
    output logic [1:0]             dbg_state
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int XW = WIDTH + 2;
    localparam logic [WIDTH:0] LOW_MASK = {(WIDTH+1){1'b1}} >> (WIDTH + 1 - APPROX_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] dvd_q, dvs_q, q_acc;
    logic [WIDTH:0]   rem_r;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   r_shift, d_ext, t_val, r_next;
    logic [XW-1:0]    diff;
    logic             borrow_k, borrow_out, q_bit;

    // The low field only decides the borrow into bit APPROX_BITS (exactly);
    // its result bits are plain XOR. Masked high operands keep zeros below
    // APPROX_BITS so the high ripple starts at that bit.
    assign r_shift    = {rem_r[WIDTH-1:0], dvd_q[idx]};
    assign d_ext      = {1'b0, dvs_q};
    assign borrow_k   = (r_shift & LOW_MASK) < (d_ext & LOW_MASK);
    assign diff       = {1'b0, r_shift & ~LOW_MASK} - {1'b0, d_ext & ~LOW_MASK}
                        - ({{(XW-1){1'b0}}, borrow_k} << APPROX_BITS);
    assign borrow_out = diff[XW-1];
    assign t_val      = (diff[WIDTH:0] & ~LOW_MASK) | ((r_shift ^ d_ext) & LOW_MASK);
    assign q_bit      = ~borrow_out;
    assign r_next     = borrow_out ? r_shift : t_val;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_next = (bus.divisor == '0) ? DONE : CALC;
            CALC: if (idx == '0)    state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            q_acc       <= '0;
            rem_r       <= '0;
            idx         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.divisor == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            dvd_q <= bus.dividend;
                            dvs_q <= bus.divisor;
                            rem_r <= '0;
                            q_acc <= '0;
                            idx   <= IW'(WIDTH - 1);
                            dbz_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r      <= r_next;
                    q_acc[idx] <= q_bit;
                    idx        <= idx - 1'b1;
                    if (idx == '0) begin
                        quotient_r  <= {q_acc[WIDTH-1:1], q_bit};
                        remainder_r <= r_next[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign dbg_state       = state;
endmodule

// File: tb/tb_a_restoring_div.sv
// Directed bench for a_restoring_div: exact (APPROX_BITS=0) and approximate
// (APPROX_BITS=2) instances share clock, reset and a selectable driver.
module tb_a_restoring_div;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       sel = 1'b0;
    logic       drv_valid = 1'b0;
    logic       drv_ready = 1'b0;
    logic [7:0] drv_a = '0;
    logic [7:0] drv_b = '0;
    logic [1:0] dbg0, dbg2;

    a_restoring_div_if #(.WIDTH(8)) if0 ();
    a_restoring_div_if #(.WIDTH(8)) if2 ();

    assign if0.in_valid  = drv_valid & ~sel;
    assign if2.in_valid  = drv_valid & sel;
    assign if0.out_ready = drv_ready & ~sel;
    assign if2.out_ready = drv_ready & sel;
    assign if0.dividend  = drv_a;
    assign if2.dividend  = drv_a;
    assign if0.divisor   = drv_b;
    assign if2.divisor   = drv_b;

    a_restoring_div #(.WIDTH(8), .APPROX_BITS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .dbg_state(dbg0));
    a_restoring_div #(.WIDTH(8), .APPROX_BITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .dbg_state(dbg2));

    wire       m_in_ready  = sel ? if2.in_ready    : if0.in_ready;
    wire       m_out_valid = sel ? if2.out_valid   : if0.out_valid;
    wire [7:0] m_q         = sel ? if2.quotient    : if0.quotient;
    wire [7:0] m_r         = sel ? if2.remainder   : if0.remainder;
    wire       m_dbz       = sel ? if2.div_by_zero : if0.div_by_zero;

    typedef struct {
        logic       sel;
        logic [7:0] a, b, q, r;
        logic       dbz;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents one operand pair, waits for the result; optionally acks it.
    // lat = edges after the accepting edge until out_valid is seen.
    task automatic run_div(input logic s, input logic [7:0] a, input logic [7:0] b,
                           input bit ack, output int lat);
        int w;
        sel = s;
        w = 0;
        while (!m_in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_op", m_in_ready, 1);
        drv_a = a; drv_b = b; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        lat = 0;
        while (!m_out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("out_valid_timeout", m_out_valid, 1);
        if (ack) begin
            drv_ready = 1'b1;
            @(posedge clk); #1;
            drv_ready = 1'b0;
        end
    endtask

    initial begin
        int lat;
        string tag;
        // sel, dividend, divisor, quotient, remainder, div_by_zero
        vecs[0]  = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,  1'b0};
        vecs[1]  = '{1'b0, 8'd255, 8'd16,  8'd15,  8'd15, 1'b0};
        vecs[2]  = '{1'b0, 8'd100, 8'd10,  8'd10,  8'd0,  1'b0};
        vecs[3]  = '{1'b0, 8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        vecs[4]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        vecs[5]  = '{1'b0, 8'd77,  8'd0,   8'd255, 8'd77, 1'b1};
        vecs[6]  = '{1'b0, 8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
        vecs[7]  = '{1'b1, 8'd13,  8'd5,   8'd3,   8'd2,  1'b0};
        vecs[8]  = '{1'b1, 8'd200, 8'd1,   8'd200, 8'd0,  1'b0};
        vecs[9]  = '{1'b1, 8'd6,   8'd5,   8'd1,   8'd3,  1'b0};
        vecs[10] = '{1'b1, 8'd9,   8'd6,   8'd1,   8'd3,  1'b0};
        vecs[11] = '{1'b1, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        vecs[12] = '{1'b1, 8'd0,   8'd0,   8'd255, 8'd0,  1'b1};
        vecs[13] = '{1'b1, 8'd7,   8'd3,   8'd2,   8'd1,  1'b0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready0",  if0.in_ready, 1);
        check("rst_out_valid0", if0.out_valid, 0);
        check("rst_quotient0",  if0.quotient, 0);
        check("rst_remainder0", if0.remainder, 0);
        check("rst_dbz0",       if0.div_by_zero, 0);
        check("rst_in_ready2",  if2.in_ready, 1);
        check("rst_out_valid2", if2.out_valid, 0);

        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].sel, vecs[i].a, vecs[i].b, 1'b0, lat);
            tag = $sformatf("v%0d_%0d/%0d", i, vecs[i].a, vecs[i].b);
            check({tag, "_quotient"},  m_q,   vecs[i].q);
            check({tag, "_remainder"}, m_r,   vecs[i].r);
            check({tag, "_dbz"},       m_dbz, vecs[i].dbz);
            // div-by-zero completes on the accepting edge itself
            check({tag, "_latency"},   lat,   vecs[i].dbz ? 0 : 8);
            drv_ready = 1'b1;
            @(posedge clk); #1;
            drv_ready = 1'b0;
            check({tag, "_back_idle"}, m_in_ready, 1);
        end

        // Back-pressure: result must hold while out_ready stays low.
        run_div(1'b0, 8'd200, 8'd7, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_out_valid", m_out_valid, 1);
            check("bp_in_ready",  m_in_ready, 0);
            check("bp_quotient",  m_q, 28);
            check("bp_remainder", m_r, 4);
        end
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
        check("bp_release_out_valid", m_out_valid, 0);
        check("bp_release_in_ready",  m_in_ready, 1);
        check("bp_release_q_held",    m_q, 28);

        // Reset on the 4th CALC edge aborts the division.
        sel = 1'b0;
        drv_a = 8'd200; drv_b = 8'd7; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_out_valid", if0.out_valid, 0);
        check("midrst_in_ready",  if0.in_ready, 1);
        check("midrst_quotient",  if0.quotient, 0);
        check("midrst_remainder", if0.remainder, 0);
        check("midrst_dbz",       if0.div_by_zero, 0);
        repeat (3) @(posedge clk); #1;
        check("midrst_no_result", if0.out_valid, 0);
        run_div(1'b0, 8'd255, 8'd16, 1'b1, lat);
        check("post_rst_quotient",  if0.quotient, 15);
        check("post_rst_remainder", if0.remainder, 15);
        check("post_rst_latency",   lat, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
